// File: rtl/sd_defs.sv
// Shared definitions for the SD picture loader: FSM states, sector geometry, retry limit
// and the sector address helper.
package sd_defs;

  localparam int unsigned SECTOR_WORDS = 256;
  localparam int unsigned RETRY_MAX    = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRoom,
    StReq,
    StBusy,
    StNext,
    StDone
  } ld_state_e;

  // Absolute sector of a picture's sector; wraps mod 2^32.
  function automatic logic [31:0] sector_addr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [1:0]  idx,
                                              input logic [15:0] sec);
    return base + stride * {30'd0, idx} + {16'd0, sec};
  endfunction

endpackage

// File: rtl/sd_rd_watchdog.sv
// Read-request watchdog: counts cycles with a request outstanding, pulses expire after
// TIMEOUT of them and tracks how many retries have been spent.
module sd_rd_watchdog import sd_defs::*; #(
  parameter logic [15:0] TIMEOUT = 16'd5000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic run_i,
  output logic expire_o,
  output logic exhausted_o
);

  logic [15:0] cnt_q;
  logic [1:0]  retry_q;

  assign expire_o    = run_i && (cnt_q == TIMEOUT - 16'd1);
  assign exhausted_o = (retry_q == 2'(RETRY_MAX));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      retry_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      retry_q <= '0;
    end else if (expire_o) begin
      cnt_q   <= '0;
      retry_q <= exhausted_o ? retry_q : retry_q + 2'd1;
    end else if (run_i) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/sd_pic_loader.sv
// Streams one picture (PIC_SECTORS consecutive sectors) out of the SD controller's read port
// into the display frame FIFO, one sector at a time.
module sd_pic_loader import sd_defs::*; #(
  parameter logic [31:0] BASE_SECTOR = 32'd8192,
  parameter logic [31:0] PIC_STRIDE  = 32'd2048,
  parameter int unsigned PIC_SECTORS = 1200,
  parameter int unsigned PIC_NUM     = 4,
  parameter logic [15:0] TIMEOUT     = 16'd5000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        pic_c,
  input  logic        fifo_afull,
  input  logic        rd_busy,
  input  logic        rd_data_en,
  input  logic [15:0] rd_data,
  output logic        rd_en,
  output logic [31:0] rd_addr,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic [1:0]  pic_idx,
  output logic        load_busy,
  output logic        load_done,
  output logic        err
);

  ld_state_e   state_q, state_d;
  logic [15:0] sec_cnt_q, sec_cnt_d;
  logic [9:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  pic_idx_q, pic_idx_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        pending_q, pending_d;
  logic        autoload_q, autoload_d;
  logic        load_busy_q, load_busy_d;
  logic        rd_en_q, rd_en_d;
  logic        err_q, err_d;
  logic        rd_busy_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;
  logic        wd_clear, wd_run, wd_expire, wd_exhausted;

  assign wd_run = (state_q == StReq) && rd_en_q;

  sd_rd_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .clear_i    (wd_clear),
    .run_i      (wd_run),
    .expire_o   (wd_expire),
    .exhausted_o(wd_exhausted)
  );

  always_comb begin
    state_d     = state_q;
    sec_cnt_d   = sec_cnt_q;
    word_cnt_d  = word_cnt_q;
    pic_idx_d   = pic_idx_q;
    rd_addr_d   = rd_addr_q;
    pending_d   = pending_q | pic_c;
    autoload_d  = autoload_q;
    load_busy_d = load_busy_q;
    rd_en_d     = 1'b0;
    err_d       = err_q;
    wd_clear    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (init_end && (autoload_q || pending_q)) begin
          sec_cnt_d   = '0;
          load_busy_d = 1'b1;
          state_d     = StRoom;
          if (autoload_q) begin
            autoload_d = 1'b0;
          end else begin
            // A pulse landing on the consuming cycle queues the following picture.
            pending_d = pic_c;
            pic_idx_d = (pic_idx_q == 2'(PIC_NUM - 1)) ? 2'd0 : pic_idx_q + 2'd1;
          end
        end
      end
      StRoom: begin
        wd_clear = 1'b1;
        if (!fifo_afull && !rd_busy) begin
          rd_addr_d = sector_addr(BASE_SECTOR, PIC_STRIDE, pic_idx_q, sec_cnt_q);
          state_d   = StReq;
        end
      end
      StReq: begin
        word_cnt_d = '0;
        if (rd_busy) begin
          state_d = StBusy;
        end else if (wd_expire) begin
          // rd_en_d stays low: one idle cycle before the retry, or give up.
          if (wd_exhausted) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end else begin
          rd_en_d = 1'b1;
        end
      end
      StBusy: begin
        if (rd_data_en) word_cnt_d = word_cnt_q + 10'd1;
        if (rd_busy_q && !rd_busy) begin
          state_d = StNext;
          if (word_cnt_d != 10'(SECTOR_WORDS)) err_d = 1'b1;
        end
      end
      StNext: begin
        if (sec_cnt_q == 16'(PIC_SECTORS - 1)) begin
          state_d = StDone;
        end else begin
          sec_cnt_d = sec_cnt_q + 16'd1;
          state_d   = StRoom;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StDone) load_busy_d = 1'b0;

    // Losing SD init abandons the load silently; err keeps whatever it already holds.
    if (!init_end && (state_q inside {StRoom, StReq, StBusy, StNext})) begin
      state_d     = StIdle;
      load_busy_d = 1'b0;
      rd_en_d     = 1'b0;
      err_d       = err_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      sec_cnt_q   <= '0;
      word_cnt_q  <= '0;
      pic_idx_q   <= '0;
      rd_addr_q   <= '0;
      pending_q   <= 1'b0;
      autoload_q  <= 1'b1;
      load_busy_q <= 1'b0;
      rd_en_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_busy_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sec_cnt_q   <= sec_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pic_idx_q   <= pic_idx_d;
      rd_addr_q   <= rd_addr_d;
      pending_q   <= pending_d;
      autoload_q  <= autoload_d;
      load_busy_q <= load_busy_d;
      rd_en_q     <= rd_en_d;
      err_q       <= err_d;
      rd_busy_q   <= rd_busy;
      out_valid_q <= rd_data_en && load_busy_q;
      if (rd_data_en && load_busy_q) out_data_q <= rd_data;
    end
  end

  assign rd_en     = rd_en_q && init_end;
  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pic_idx   = pic_idx_q;
  assign load_busy = load_busy_q;
  assign load_done = (state_q == StDone);
  assign err       = err_q;

endmodule

// File: tb/tb_sd_pic_loader.sv
// Scoreboard bench for sd_pic_loader: expected sector addresses and picture words are queued
// by the stimulus; a monitor pops and compares whenever the loader presents them.
module tb_sd_pic_loader;

  localparam logic [15:0] TMO  = 16'd200;
  localparam int unsigned NSEC = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        init_end = 1'b0;
  logic        pic_c = 1'b0;
  logic        fifo_afull = 1'b0;
  logic        rd_busy = 1'b0;
  logic        rd_data_en = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  pic_idx;
  logic        load_busy;
  logic        load_done;
  logic        err;

  sd_pic_loader #(
    .PIC_SECTORS(NSEC),
    .TIMEOUT    (TMO)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .pic_c     (pic_c),
    .fifo_afull(fifo_afull),
    .rd_busy   (rd_busy),
    .rd_data_en(rd_data_en),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pic_idx   (pic_idx),
    .load_busy (load_busy),
    .load_done (load_done),
    .err       (err)
  );

  always #10 sys_clk = ~sys_clk;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          beat_cnt = 0;
  int          rise_cyc[$];
  logic [31:0] addr_q[$];
  logic [15:0] data_q[$];
  logic        rd_en_prev = 1'b0;
  logic        sd_mute = 1'b0;
  logic [31:0] sd_short_addr = 32'hFFFF_FFFF;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_word(input logic [31:0] a, input int i);
    return {a[15:8] ^ a[7:0], 8'(i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge sys_clk);
      if (rd_en && !rd_en_prev) begin
        rise_cnt++;
        rise_cyc.push_back(cyc);
        if (addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_addr: unexpected request for sector %0d", rd_addr);
        end else begin
          check("rd_addr", rd_addr, addr_q.pop_front());
        end
      end
      rd_en_prev = rd_en;
      if (out_valid) begin
        beat_cnt++;
        if (data_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_data: unexpected word 0x%0h", out_data);
        end else begin
          check("out_data", {16'd0, out_data}, {16'd0, data_q.pop_front()});
        end
      end
      if (load_done) done_cnt++;
    end
  end

  // SD controller model: 1 idle cycle after busy, then the sector's words back to back.
  initial begin
    logic [31:0] a;
    int          n;
    forever begin
      @(negedge sys_clk);
      if (rd_en && !sd_mute) begin
        a = rd_addr;
        n = (a == sd_short_addr) ? 255 : 256;
        @(posedge sys_clk); #1 rd_busy = 1'b1;
        @(posedge sys_clk); #1;
        for (int i = 0; i < n; i++) begin
          rd_data_en = 1'b1;
          rd_data    = exp_word(a, i);
          @(posedge sys_clk); #1;
        end
        rd_data_en = 1'b0;
        @(posedge sys_clk); #1 rd_busy = 1'b0;
        @(posedge sys_clk); #1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_load(input logic [31:0] base, input int first_words);
    for (int s = 0; s < NSEC; s++) begin
      addr_q.push_back(base + 32'(s));
      for (int i = 0; i < ((s == 0) ? first_words : 256); i++)
        data_q.push_back(exp_word(base + 32'(s), i));
    end
  endtask

  task automatic pulse_pic();
    pic_c = 1'b1;
    tick(1);
    pic_c = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (done_cnt < target && t < budget) begin
      tick(1);
      t++;
    end
    check("load_done_count", done_cnt, target);
  endtask

  task automatic wait_rise(input int target, input int budget);
    int t = 0;
    while (rise_cnt < target && t < budget) begin
      tick(1);
      t++;
    end
    check("rd_en_rise_count", rise_cnt, target);
  endtask

  task automatic do_reset();
    sys_rst_n     = 1'b0;
    init_end      = 1'b0;
    pic_c         = 1'b0;
    fifo_afull    = 1'b0;
    sd_mute       = 1'b0;
    sd_short_addr = 32'hFFFF_FFFF;
    tick(3);
    check("reset_rd_en", rd_en, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_pic_idx", pic_idx, 0);
    check("reset_load_busy", load_busy, 0);
    check("reset_load_done", load_done, 0);
    check("reset_err", err, 0);
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    int d0;
    int r0;
    int rb;
    do_reset();

    // Autoload of picture 0 with three pic_c pulses mid-load -> exactly one extra load.
    expect_load(32'd8192, 256);
    expect_load(32'd10240, 256);
    while (cyc < 100) tick(1);
    init_end = 1'b1;
    wait_rise(1, 50);
    tick(10); pulse_pic();
    tick(5);  pulse_pic();
    tick(5);  pulse_pic();
    wait_done(1, 3000);
    check("beats_pic0", beat_cnt, 1024);
    check("err_pic0", err, 0);
    wait_done(2, 3000);
    check("pic_idx_1", pic_idx, 1);
    tick(50);
    check("single_extra_load", done_cnt, 2);
    check("idle_after_loads", load_busy, 0);
    check("beats_pic1", beat_cnt, 2048);

    // Picture 2 with fifo_afull held between sectors.
    expect_load(32'd12288, 256);
    r0 = rise_cnt;
    pulse_pic();
    wait_rise(r0 + 1, 50);
    fifo_afull = 1'b1;
    r0 = rise_cnt;
    tick(500);
    check("afull_no_request", rise_cnt, r0);
    check("afull_rd_en_low", rd_en, 0);
    fifo_afull = 1'b0;
    wait_done(3, 4000);
    check("pic_idx_2", pic_idx, 2);

    expect_load(32'd14336, 256);
    pulse_pic();
    wait_done(4, 3000);
    check("pic_idx_3", pic_idx, 3);

    expect_load(32'd8192, 256);
    pulse_pic();
    wait_done(5, 3000);
    check("pic_idx_wrap", pic_idx, 0);
    check("beats_all", beat_cnt, 5 * 1024);
    check("addr_q_drained", addr_q.size(), 0);
    check("data_q_drained", data_q.size(), 0);

    // Short first sector: load still completes with err set.
    do_reset();
    sd_short_addr = 32'd8192;
    expect_load(32'd8192, 255);
    d0 = done_cnt;
    init_end = 1'b1;
    wait_done(d0 + 1, 3000);
    check("short_err", err, 1);
    check("short_data_drained", data_q.size(), 0);

    // SD never answers: 3 retries TIMEOUT+1 apart, then err and load_done.
    do_reset();
    sd_mute = 1'b1;
    for (int k = 0; k < 4; k++) addr_q.push_back(32'd8192);
    rb = rise_cyc.size();
    d0 = done_cnt;
    init_end = 1'b1;
    wait_done(d0 + 1, 2000);
    check("timeout_err", err, 1);
    check("timeout_requests", rise_cyc.size() - rb, 4);
    for (int k = 1; k < 4; k++)
      check("retry_gap", rise_cyc[rb + k] - rise_cyc[rb + k - 1], 32'(TMO) + 1);
    check("timeout_idle", load_busy, 0);

    // init_end dropped during a request: rd_en falls at once, no load_done.
    do_reset();
    sd_mute = 1'b1;
    addr_q.push_back(32'd8192);
    d0 = done_cnt;
    r0 = rise_cnt;
    init_end = 1'b1;
    wait_rise(r0 + 1, 50);
    tick(3);
    check("abort_rd_en_before", rd_en, 1);
    init_end = 1'b0;
    #1;
    check("abort_rd_en_same_cycle", rd_en, 0);
    tick(1);
    check("abort_load_busy", load_busy, 0);
    tick(20);
    check("abort_no_done", done_cnt, d0);
    check("abort_err", err, 0);
    check("abort_no_requests", rise_cnt, r0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
